// File: rtl/data_memory_pipe.sv
// Byte-lane data memory with one-cycle responses. Accesses that cross into the
// next row take a second cycle (SPLIT) to update or read the upper row.
module data_memory_pipe #(
  parameter int XLEN        = 32,
  parameter int DEPTH_BYTES = 8192,
  parameter int MISALIGN_EN = 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_we_i,
  input  logic [XLEN-1:0] req_addr_i,
  input  logic [XLEN-1:0] req_wdata_i,
  input  logic [1:0]      req_size_i,
  input  logic            req_sign_ext_i,
  output logic            rsp_valid_o,
  output logic [XLEN-1:0] rsp_rdata_o,
  output logic            rsp_err_o,
  output logic            dbg_state_o
);

  localparam int L    = XLEN / 8;
  localparam int LW   = $clog2(L);
  localparam int ROWS = DEPTH_BYTES / L;
  localparam int RW   = $clog2(ROWS);

  typedef enum logic {IDLE = 1'b0, SPLIT = 1'b1} state_t;

  // Handshake: a request is taken on a rising edge with req_valid_i && req_ready_o;
  // exactly one rsp_valid_o pulse follows unless reset intervenes mid-SPLIT.
  state_t r_state;
  state_t w_state_nxt;

  logic [XLEN-1:0] r_mem [ROWS];

  logic [LW-1:0]     w_lane;
  logic [RW-1:0]     w_row;
  logic [3:0]        w_n;
  logic [XLEN:0]     w_end;
  logic              w_cross;
  logic              w_err;
  logic              w_accept;
  logic [L-1:0]      w_mask;
  logic [2*L-1:0]    w_be_wide;
  logic [2*XLEN-1:0] w_wdata_wide;
  logic [XLEN-1:0]   w_rd_lo;
  logic [XLEN-1:0]   w_rd_hi;

  logic            w_mem_we;
  logic [RW-1:0]   w_mem_row;
  logic [L-1:0]    w_mem_be;
  logic [XLEN-1:0] w_mem_wdata;

  logic            r_we;
  logic            r_sx;
  logic [LW-1:0]   r_lane;
  logic [3:0]      r_n;
  logic [RW-1:0]   r_hi_row;
  logic [L-1:0]    r_hi_be;
  logic [XLEN-1:0] r_hi_wdata;
  logic [XLEN-1:0] r_lo_rdata;
  logic            r_rsp_valid;
  logic            r_rsp_err;
  logic [XLEN-1:0] r_rsp_rdata;

  // Picks N bytes starting at the lane out of a two-row window, then extends.
  function automatic logic [XLEN-1:0] f_extract(input logic [2*XLEN-1:0] win,
                                                input logic [LW-1:0] lane,
                                                input logic [3:0] n,
                                                input logic sx);
    logic [XLEN-1:0] v;
    logic            s;
    v = XLEN'(win >> {lane, 3'b000});
    s = 1'b0;
    for (int b = 0; b < L; b++) if (b == int'(n) - 1) s = sx & v[b*8+7];
    for (int b = 0; b < L; b++) if (b >= int'(n)) v[b*8 +: 8] = {8{s}};
    return v;
  endfunction

  assign w_lane      = req_addr_i[LW-1:0];
  assign w_row       = req_addr_i[LW +: RW];
  assign w_accept    = req_valid_i && (r_state == IDLE);
  assign req_ready_o = (r_state == IDLE);
  assign dbg_state_o = r_state;
  assign w_rd_lo     = r_mem[w_row];
  assign w_rd_hi     = r_mem[r_hi_row];

  always_comb begin
    w_n   = 4'd1 << req_size_i;
    w_end = {1'b0, req_addr_i} + {{(XLEN-3){1'b0}}, w_n} - {{XLEN{1'b0}}, 1'b1};
    w_cross = (int'(w_lane) + int'(w_n)) > L;
    w_err = ((XLEN == 32) && (req_size_i == 2'b11))
         || (w_end >= (XLEN+1)'(DEPTH_BYTES))
         || (w_cross && (MISALIGN_EN == 0));
    for (int b = 0; b < L; b++) w_mask[b] = (b < int'(w_n));
    w_be_wide    = {{L{1'b0}}, w_mask} << w_lane;
    w_wdata_wide = {{XLEN{1'b0}}, req_wdata_i} << {w_lane, 3'b000};
  end

  // Single write port: upper-row bytes in SPLIT, lower-row bytes at acceptance.
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_row   = w_row;
    w_mem_be    = '0;
    w_mem_wdata = '0;
    if (r_state == SPLIT) begin
      w_mem_we    = r_we;
      w_mem_row   = r_hi_row;
      w_mem_be    = r_hi_be;
      w_mem_wdata = r_hi_wdata;
    end else if (w_accept && !w_err && req_we_i) begin
      w_mem_we    = 1'b1;
      w_mem_be    = w_be_wide[L-1:0];
      w_mem_wdata = w_wdata_wide[XLEN-1:0];
    end
  end

  // No reset here: contents survive reset by design.
  always_ff @(posedge clk_i) begin
    if (w_mem_we) begin
      for (int b = 0; b < L; b++)
        if (w_mem_be[b]) r_mem[w_mem_row][b*8 +: 8] <= w_mem_wdata[b*8 +: 8];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept && !w_err && w_cross) w_state_nxt = SPLIT;
      SPLIT:   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_we        <= 1'b0;
      r_sx        <= 1'b0;
      r_lane      <= '0;
      r_n         <= '0;
      r_hi_row    <= '0;
      r_hi_be     <= '0;
      r_hi_wdata  <= '0;
      r_lo_rdata  <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
      if (r_state == SPLIT) begin
        r_rsp_valid <= 1'b1;
        if (!r_we) r_rsp_rdata <= f_extract({w_rd_hi, r_lo_rdata}, r_lane, r_n, r_sx);
      end else if (w_accept) begin
        r_we       <= req_we_i;
        r_sx       <= req_sign_ext_i;
        r_lane     <= w_lane;
        r_n        <= w_n;
        r_hi_row   <= w_row + RW'(1);
        r_hi_be    <= w_be_wide[2*L-1:L];
        r_hi_wdata <= w_wdata_wide[2*XLEN-1:XLEN];
        r_lo_rdata <= w_rd_lo;
        if (w_err) begin
          r_rsp_valid <= 1'b1;
          r_rsp_err   <= 1'b1;
        end else if (!w_cross) begin
          r_rsp_valid <= 1'b1;
          if (!req_we_i)
            r_rsp_rdata <= f_extract({{XLEN{1'b0}}, w_rd_lo}, w_lane, w_n, req_sign_ext_i);
        end
      end
    end
  end

  assign rsp_valid_o = r_rsp_valid;
  assign rsp_err_o   = r_rsp_err;
  assign rsp_rdata_o = r_rsp_rdata;

endmodule

// File: doc/data_memory_pipe.md
DATA_MEMORY_PIPE -- requirements
Module: data_memory_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address width; legal values 32 or 64.
REQ-002 SHALL have parameter DEPTH_BYTES, default 8192, byte capacity; power of two, at least 2*XLEN/8.
REQ-003 SHALL have parameter MISALIGN_EN, default 1; 1 splits lane-crossing accesses, 0 faults them.
REQ-004 SHALL have port clk_i  in  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_ni  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port req_valid_i  in  1  request present.
REQ-007 SHALL have port req_ready_o  out  1  request can be accepted this cycle.
REQ-008 SHALL have port req_we_i  in  1  1 store, 0 load.
REQ-009 SHALL have port req_addr_i  in  XLEN  byte address.
REQ-010 SHALL have port req_wdata_i  in  XLEN  store data, LSB-aligned.
REQ-011 SHALL have port req_size_i  in  2  00 byte, 01 half, 10 word, 11 dword.
REQ-012 SHALL have port req_sign_ext_i  in  1  1 sign-extend load, 0 zero-extend.
REQ-013 SHALL have port rsp_valid_o  out  1  one-cycle response strobe, issued for loads and stores.
REQ-014 SHALL have port rsp_rdata_o  out  XLEN  load data; 0 for stores and errors.
REQ-015 SHALL have port rsp_err_o  out  1  access fault, qualified by rsp_valid_o.

Function
REQ-016 SHALL store data as XLEN/8 byte lanes, little-endian; row = addr / (XLEN/8), lane = addr mod (XLEN/8).
REQ-017 SHALL accept a request on a rising edge where req_valid_i and req_ready_o are both 1 (edge E0).
REQ-018 SHALL use an FSM with states IDLE, SPLIT; req_ready_o = 1 only in IDLE.
REQ-019 SHALL compute access bytes N = 1,2,4,8 from req_size_i; size 11 with XLEN=32 SHALL be an error.
REQ-020 SHALL flag an error if addr+N-1 >= DEPTH_BYTES (computed at XLEN+1 bits, no wrap-around).
REQ-021 SHALL classify an access as lane-crossing when lane+N > XLEN/8.
REQ-022 SHALL flag an error for lane-crossing accesses when MISALIGN_EN=0.
REQ-023 SHALL, on error, perform no memory write, stay IDLE, and assert rsp_valid_o=1, rsp_err_o=1, rsp_rdata_o=0 in the cycle after E0.
REQ-024 SHALL complete a non-crossing access at E0 (byte-enabled write or row read) with rsp_valid_o=1 in the cycle after E0; FSM stays IDLE.
REQ-025 SHALL, for a crossing access, handle the low-row lanes at E0, enter SPLIT, handle the row+1 lanes at E1, return to IDLE; rsp_valid_o=1 in the cycle after E1.
REQ-026 SHALL latch addr, size, sign_ext, we and wdata at E0; input changes during SPLIT SHALL be ignored.
REQ-027 SHALL assemble load bytes little-endian, then sign-extend (bit 8N-1) or zero-extend to XLEN.
REQ-028 SHALL write only bytes [addr, addr+N-1]; all other bytes unchanged.
REQ-029 SHALL sustain one non-crossing access per cycle back-to-back; a read following a write to the same byte returns the new data.
REQ-030 SHALL drive rsp_err_o=0 and rsp_rdata_o=0 whenever rsp_valid_o=0.

Reset
REQ-031 SHALL, while rst_ni=0, force FSM=IDLE, rsp_valid_o=0, rsp_err_o=0, rsp_rdata_o=0, req_ready_o=1.
REQ-032 SHALL NOT clear memory contents on reset.
REQ-033 SHALL, on reset during SPLIT, abort without response; the low-row bytes already written SHALL remain and the high-row bytes SHALL be unwritten.

Verification
REQ-034 Default params: store word 0xDEADBEEF @0x10, then load word @0x10 -> rsp_valid_o one cycle after each acceptance, rdata=0xDEADBEEF, err=0.
REQ-035 Load byte signed @0x13 after REQ-034 -> 0xFFFFFFDE; the same load unsigned -> 0x000000DE.
REQ-036 Store word 0x11223344 @0x1E -> req_ready_o=0 for one cycle, response 2 cycles after E0; load word @0x1E -> 0x11223344, bytes 0x1C/0x1D and 0x22/0x23 unchanged.
REQ-037 MISALIGN_EN=0: load half @0x1F -> err=1, rdata=0, no stall; load word @0x1FFC -> err=0; load word @0x1FFE -> err=1.
REQ-038 Assert rst_ni=0 in the SPLIT cycle of a store word @0x22 -> no response, FSM IDLE; bytes 0x22/0x23 written, 0x24/0x25 unchanged.
REQ-039 XLEN=64: store dword 0x0123456789ABCDEF @0x3C, load dword @0x3C -> same value via split; size 11 with XLEN=32 -> err=1.
